// File: rtl/bp_pkg.sv
// Shared helpers for the branch target predictor: geometry derivation and counter constants.
package bp_pkg;

  // Index bits selecting one of the BTB entries.
  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Tag bits: everything above the index; bit 0 is dropped (halfword aligned).
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned entries);
    return addr_w - idx_w(entries) - 1;
  endfunction

  // Weakly not-taken: just below the taken threshold.
  function automatic int unsigned ctr_rst(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 1;
  endfunction

  // Weakly taken: value given to a freshly allocated entry.
  function automatic int unsigned ctr_alloc(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter with a synchronous load; load wins over inc/dec.
module bp_sat_counter #(
  parameter int unsigned W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] CntMax = '1;

  logic [W-1:0] r_cnt;

  // Count state: load, else step one way unless pinned at the matching limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc && !i_dec && (r_cnt != CntMax)) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry direction counters, mispredict detection and statistics.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, ENTRIES);
  localparam logic [CTR_W-1:0] CtrRst   = CTR_W'(ctr_rst(CTR_W));
  localparam logic [CTR_W-1:0] CtrAlloc = CTR_W'(ctr_alloc(CTR_W));

  // Direction counter of each entry lives in its own bp_sat_counter instance.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } bp_entry_t;

  bp_entry_t        r_entry [ENTRIES];
  logic [CTR_W-1:0] w_ctr   [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  logic             w_lk_hit, w_up_hit;
  logic             w_up_br, w_br_hit, w_alloc, w_inval, w_mis;

  assign w_lk_idx = lk_pc[IDX_W:1];
  assign w_lk_tag = lk_pc[ADDR_W-1:IDX_W+1];
  assign w_up_idx = upd_pc[IDX_W:1];
  assign w_up_tag = upd_pc[ADDR_W-1:IDX_W+1];

  assign w_lk_hit = r_entry[w_lk_idx].valid && (r_entry[w_lk_idx].tag == w_lk_tag);
  assign w_up_hit = r_entry[w_up_idx].valid && (r_entry[w_up_idx].tag == w_up_tag);

  assign lk_taken  = w_lk_hit && w_ctr[w_lk_idx][CTR_W-1];
  assign lk_target = lk_taken ? r_entry[w_lk_idx].target : lk_pc + ADDR_W'(2);

  assign w_up_br  = upd_valid && upd_is_branch;
  assign w_br_hit = w_up_br && w_up_hit;
  assign w_alloc  = w_up_br && !w_up_hit && upd_taken;
  // A non-branch that hits means the entry belongs to something else: drop it.
  assign w_inval  = upd_valid && !upd_is_branch && w_up_hit;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic w_sel;
    assign w_sel = (w_up_idx == IDX_W'(g));
    bp_sat_counter #(
      .W       (CTR_W),
      .RST_VAL (CtrRst)
    ) u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_sel && w_alloc),
      .i_load_val (CtrAlloc),
      .i_inc      (w_sel && w_br_hit && upd_taken),
      .i_dec      (w_sel && w_br_hit && !upd_taken),
      .o_cnt      (w_ctr[g])
    );
  end

  // Entry storage: allocate on taken miss, refresh target on taken hit, invalidate false hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_entry[i] <= '0;
      end
    end else if (w_alloc) begin
      r_entry[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: upd_target};
    end else if (w_br_hit && upd_taken) begin
      r_entry[w_up_idx].target <= upd_target;
    end else if (w_inval) begin
      r_entry[w_up_idx].valid <= 1'b0;
    end
  end

  // Mispredict: wrong direction, or right direction with a wrong taken target.
  always_comb begin
    w_mis = 1'b0;
    if (upd_is_branch) begin
      w_mis = upd_valid && ((upd_taken != upd_pred_taken) ||
                            (upd_taken && (upd_target != upd_pred_target)));
    end else begin
      w_mis = upd_valid && upd_pred_taken;
    end
  end

  assign mispredict  = w_mis;
  assign redirect_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + ADDR_W'(2);

  bp_sat_counter #(
    .W       (STAT_W),
    .RST_VAL ('0)
  ) u_stat_br (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (stat_clr),
    .i_load_val ('0),
    .i_inc      (w_up_br),
    .i_dec      (1'b0),
    .o_cnt      (stat_branches)
  );

  bp_sat_counter #(
    .W       (STAT_W),
    .RST_VAL ('0)
  ) u_stat_mis (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (stat_clr),
    .i_load_val ('0),
    .i_inc      (w_mis),
    .i_dec      (1'b0),
    .o_cnt      (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: the driver pushes expected per-cycle outputs from a behavioural model,
// the monitor pops and compares on the falling edge.
module tb_branch_target_predictor;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned STAT_W  = 4;

  localparam int CtrMax    = (1 << CTR_W) - 1;
  localparam int CtrAlloc  = 1 << (CTR_W - 1);
  localparam int StatMax   = (1 << STAT_W) - 1;
  localparam int IdxSpan   = 2 * ENTRIES;  // bytes covered by one pass over the table

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] lk_pc = '0;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] upd_pc = '0;
  logic              upd_is_branch = 1'b0;
  logic              upd_taken = 1'b0;
  logic [ADDR_W-1:0] upd_target = '0;
  logic              upd_pred_taken = 1'b0;
  logic [ADDR_W-1:0] upd_pred_target = '0;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stat_clr = 1'b0;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  branch_target_predictor #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W),
    .STAT_W  (STAT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lk_pc            (lk_pc),
    .lk_taken         (lk_taken),
    .lk_target        (lk_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_branch    (upd_is_branch),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_clr         (stat_clr),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              tk;
    logic [ADDR_W-1:0] tgt;
    logic              mis;
    logic [ADDR_W-1:0] rd;
    logic [STAT_W-1:0] sb;
    logic [STAT_W-1:0] sm;
  } exp_t;

  exp_t  q_exp [$];
  string q_name[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model: a table keyed by halfword slot, counters as plain integers.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_br, m_mis;

  function automatic int unsigned slot(input int unsigned pc);
    return (pc / 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / IdxSpan;
  endfunction

  function automatic logic [ADDR_W-1:0] plus2(input int unsigned pc);
    return ADDR_W'((pc + 2) % (1 << ADDR_W));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = CtrAlloc - 1;
    end
    m_br  = 0;
    m_mis = 0;
  endfunction

  function automatic bit model_hit(input int unsigned pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
  endfunction

  function automatic void model_lookup(input int unsigned pc, output logic tk,
                                       output logic [ADDR_W-1:0] tgt);
    tk  = model_hit(pc) && (m_ctr[slot(pc)] >= CtrAlloc);
    tgt = tk ? ADDR_W'(m_tgt[slot(pc)]) : plus2(pc);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, predict what the DUT shows
  // before the next rising edge, then advance the model to the post-edge state.
  task automatic step(input string nm, input bit rst, input bit clr, input int unsigned lpc,
                      input bit uv, input int unsigned upc, input bit ibr, input bit tk,
                      input int unsigned tgt, input bit ptk, input int unsigned ptgt);
    exp_t e;
    bit   hit;
    int   ix;
    @(posedge clk);
    #1;
    rst_n           = !rst;
    stat_clr        = clr;
    lk_pc           = ADDR_W'(lpc);
    upd_valid       = uv;
    upd_pc          = ADDR_W'(upc);
    upd_is_branch   = ibr;
    upd_taken       = tk;
    upd_target      = ADDR_W'(tgt);
    upd_pred_taken  = ptk;
    upd_pred_target = ADDR_W'(ptgt);
    if (rst) model_reset();
    model_lookup(lpc, e.tk, e.tgt);
    if (ibr) e.mis = uv && ((tk != ptk) || (tk && (tgt != ptgt)));
    else     e.mis = uv && ptk;
    e.rd = (ibr && tk) ? ADDR_W'(tgt) : plus2(upc);
    e.sb = STAT_W'(m_br);
    e.sm = STAT_W'(m_mis);
    q_exp.push_back(e);
    q_name.push_back(nm);
    if (!rst) begin
      ix  = int'(slot(upc));
      hit = model_hit(upc);
      if (uv && ibr) begin
        if (hit) begin
          m_ctr[ix] = tk ? ((m_ctr[ix] < CtrMax) ? m_ctr[ix] + 1 : CtrMax)
                         : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
          if (tk) m_tgt[ix] = tgt;
        end else if (tk) begin
          m_valid[ix] = 1'b1;
          m_tag[ix]   = tag_of(upc);
          m_tgt[ix]   = tgt;
          m_ctr[ix]   = CtrAlloc;
        end
      end else if (uv && hit) begin
        m_valid[ix] = 1'b0;
      end
      if (clr) m_br = 0;
      else if (uv && ibr && m_br < StatMax) m_br++;
      if (clr) m_mis = 0;
      else if (e.mis && m_mis < StatMax) m_mis++;
    end
  endtask

  task automatic look(input string nm, input int unsigned lpc);
    step(nm, 1'b0, 1'b0, lpc, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic rst_step(input string nm, input int unsigned lpc);
    step(nm, 1'b1, 1'b0, lpc, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  // Branch update at pc, carrying the model's own prediction down the pipe.
  task automatic br_upd(input string nm, input int unsigned lpc, input int unsigned upc,
                        input bit tk, input int unsigned tgt);
    logic              ptk;
    logic [ADDR_W-1:0] ptgt;
    model_lookup(upc, ptk, ptgt);
    step(nm, 1'b0, 1'b0, lpc, 1'b1, upc, 1'b1, tk, tgt, ptk, int'(ptgt));
  endtask

  function automatic int unsigned gen_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFE;
    return ($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) |
           (($urandom_range(0, 7) == 0) ? 1 : 0);
  endfunction

  // Monitor: the outputs are presented every cycle; compare against the oldest expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        chk({nm, ".lk_taken"}, 32'(lk_taken), 32'(e.tk));
        chk({nm, ".lk_target"}, 32'(lk_target), 32'(e.tgt));
        chk({nm, ".mispredict"}, 32'(mispredict), 32'(e.mis));
        chk({nm, ".redirect_pc"}, 32'(redirect_pc), 32'(e.rd));
        chk({nm, ".stat_branches"}, 32'(stat_branches), 32'(e.sb));
        chk({nm, ".stat_mispredicts"}, 32'(stat_mispredicts), 32'(e.sm));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_step("reset0", 32'h0010);
    rst_step("reset1", 32'h0010);
    look("wrap", 32'hFFFE);

    step("alloc", 1'b0, 1'b0, 32'h0010, 1'b1, 32'h0010, 1'b1, 1'b1, 32'h0040, 1'b0, 32'h0012);
    look("alloc_hit", 32'h0010);

    br_upd("hyst_nt", 32'h0010, 32'h0010, 1'b0, 32'h0040);
    look("hyst_ctr1", 32'h0010);
    br_upd("hyst_t1", 32'h0010, 32'h0010, 1'b1, 32'h0040);
    br_upd("hyst_t2", 32'h0010, 32'h0010, 1'b1, 32'h0040);
    br_upd("hyst_nt2", 32'h0010, 32'h0010, 1'b0, 32'h0040);
    look("hyst_ctr2", 32'h0010);
    br_upd("hyst_sat0", 32'h0010, 32'h0010, 1'b1, 32'h0040);
    br_upd("hyst_sat1", 32'h0010, 32'h0010, 1'b1, 32'h0040);
    br_upd("hyst_sat2", 32'h0010, 32'h0010, 1'b1, 32'h0040);
    br_upd("hyst_nt3", 32'h0010, 32'h0010, 1'b0, 32'h0040);
    look("hyst_ctr2b", 32'h0010);

    look("alias_miss", 32'h0030);
    br_upd("alias_alloc", 32'h0030, 32'h0030, 1'b1, 32'h0100);
    look("alias_old", 32'h0010);
    look("alias_new", 32'h0030);

    br_upd("realloc", 32'h0010, 32'h0010, 1'b1, 32'h0040);
    step("nonbr_hit", 1'b0, 1'b0, 32'h0010, 1'b1, 32'h0010, 1'b0, 1'b0, 0, 1'b1, 32'h0040);
    look("nonbr_inval", 32'h0010);

    for (int i = 0; i < 16; i++) br_upd("stat_sat", 32'h0020, 32'h0200, 1'b0, 0);
    look("stat_held", 32'h0020);
    step("stat_clr", 1'b0, 1'b1, 32'h0020, 1'b1, 32'h0200, 1'b1, 1'b1, 32'h0300, 1'b0, 0);
    look("stat_cleared", 32'h0200);

    br_upd("pre_rst", 32'h0044, 32'h0044, 1'b1, 32'h0abc);
    look("pre_rst_hit", 32'h0044);
    rst_step("mid_rst", 32'h0044);
    look("post_rst", 32'h0044);

    for (int n = 0; n < 1500; n++) begin
      int unsigned       upc, tgt, ptgt;
      bit                uv, ibr, tk, ptk;
      logic              mtk;
      logic [ADDR_W-1:0] mtgt;
      if ($urandom_range(0, 199) == 0) begin
        rst_step("rnd_rst", gen_pc());
        continue;
      end
      upc = gen_pc();
      uv  = ($urandom_range(0, 9) < 8);
      ibr = ($urandom_range(0, 9) < 6);
      tk  = $urandom_range(0, 1);
      tgt = $urandom_range(0, 7) << 4;
      model_lookup(upc, mtk, mtgt);
      if ($urandom_range(0, 9) < 7) begin
        ptk  = mtk;
        ptgt = int'(mtgt);
      end else begin
        ptk  = $urandom_range(0, 1);
        ptgt = $urandom_range(0, 7) << 4;
      end
      step("rnd", 1'b0, ($urandom_range(0, 49) == 0), gen_pc(), uv, upc, ibr, tk, tgt,
           ptk, ptgt);
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
